// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-lane round-robin arbiter sequencing the shared fixed-latency data-memory port
// Optional feature macro: DMEM_ARB_STATS_EN (adds conflict_cnt / wait_cnt statistics outputs)
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l0_req_valid,
    input  logic                  l0_req_we,
    input  logic [ADDR_W-1:0]     l0_req_addr,
    input  logic [DATA_W-1:0]     l0_req_wdata,
    input  logic [DATA_W/8-1:0]   l0_req_be,
    output logic                  l0_req_ready,
    output logic                  l0_rsp_valid,
    output logic [DATA_W-1:0]     l0_rsp_rdata,
    input  logic                  l1_req_valid,
    input  logic                  l1_req_we,
    input  logic [ADDR_W-1:0]     l1_req_addr,
    input  logic [DATA_W-1:0]     l1_req_wdata,
    input  logic [DATA_W/8-1:0]   l1_req_be,
    output logic                  l1_req_ready,
    output logic                  l1_rsp_valid,
    output logic [DATA_W-1:0]     l1_rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [CNT_W-1:0]      conflict_cnt,
    output logic [CNT_W-1:0]      wait_cnt,
`endif
    output logic                  busy
);
    localparam int WCNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    logic                rr;
    logic                owner;
    logic                lat_we;
    logic [WCNT_W-1:0]   wcnt;
    logic                both_valid;
    logic                any_valid;
    logic                grant;
    logic                hs;

    always_comb begin
        both_valid   = l0_req_valid & l1_req_valid;
        any_valid    = l0_req_valid | l1_req_valid;
        grant        = both_valid ? rr : l1_req_valid;
        hs           = reset && (state == IDLE) && any_valid;
        l0_req_ready = hs && !grant;
        l1_req_ready = hs && grant;
    end

    assign busy = (state != IDLE);

    // mem_addr/wdata/be double as the latched request fields and hold between accesses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rr           <= 1'b0;
            owner        <= 1'b0;
            lat_we       <= 1'b0;
            wcnt         <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            l0_rsp_valid <= 1'b0;
            l0_rsp_rdata <= '0;
            l1_rsp_valid <= 1'b0;
            l1_rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner     <= grant;
                        rr        <= ~grant;
                        lat_we    <= grant ? l1_req_we    : l0_req_we;
                        mem_we    <= grant ? l1_req_we    : l0_req_we;
                        mem_addr  <= grant ? l1_req_addr  : l0_req_addr;
                        mem_wdata <= grant ? l1_req_wdata : l0_req_wdata;
                        mem_be    <= grant ? l1_req_be    : l0_req_be;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    wcnt   <= WCNT_W'(MEM_LAT);
                    state  <= WAIT;
                end
                WAIT: begin
                    if (wcnt == WCNT_W'(1)) begin
                        state <= RESP;
                        if (owner) begin
                            l1_rsp_valid <= 1'b1;
                            l1_rsp_rdata <= lat_we ? '0 : mem_rdata;
                        end else begin
                            l0_rsp_valid <= 1'b1;
                            l0_rsp_rdata <= lat_we ? '0 : mem_rdata;
                        end
                    end else begin
                        wcnt <= wcnt - WCNT_W'(1);
                    end
                end
                RESP: begin
                    l0_rsp_valid <= 1'b0;
                    l1_rsp_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic any_wait;
    assign any_wait = (l0_req_valid & ~l0_req_ready) | (l1_req_valid & ~l1_req_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt <= '0;
            wait_cnt     <= '0;
        end else begin
            if (hs && both_valid && conflict_cnt != CNT_MAX)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            if (any_wait && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - bench for dmem_port_arbiter: timeline model, memory responder, directed vectors
module tb_dmem_port_arbiter;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        l0_req_valid, l0_req_we, l0_req_ready, l0_rsp_valid;
    logic [31:0] l0_req_addr, l0_req_wdata, l0_rsp_rdata;
    logic [3:0]  l0_req_be;
    logic        l1_req_valid, l1_req_we, l1_req_ready, l1_rsp_valid;
    logic [31:0] l1_req_addr, l1_req_wdata, l1_rsp_rdata;
    logic [3:0]  l1_req_be;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef DMEM_ARB_STATS_EN
    logic [CW-1:0] conflict_cnt, wait_cnt;
`endif

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .l0_req_valid(l0_req_valid), .l0_req_we(l0_req_we), .l0_req_addr(l0_req_addr),
        .l0_req_wdata(l0_req_wdata), .l0_req_be(l0_req_be), .l0_req_ready(l0_req_ready),
        .l0_rsp_valid(l0_rsp_valid), .l0_rsp_rdata(l0_rsp_rdata),
        .l1_req_valid(l1_req_valid), .l1_req_we(l1_req_we), .l1_req_addr(l1_req_addr),
        .l1_req_wdata(l1_req_wdata), .l1_req_be(l1_req_be), .l1_req_ready(l1_req_ready),
        .l1_rsp_valid(l1_rsp_valid), .l1_rsp_rdata(l1_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .wait_cnt(wait_cnt),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // bench-side memory answering the DUT, and the model's reference copy
    logic [31:0] dmem  [logic [31:0]];
    logic [31:0] rmem  [logic [31:0]];
    logic [31:0] rd_at [int];

    req_t q0[$], q1[$];
    logic acc0 = 1'b0, acc1 = 1'b0;

    // observation logs for the hand-computed checks
    int          hs_cyc[2], hs_cnt[2], rsp_cyc[2], rsp_cnt[2];
    logic [31:0] rsp_dat[2];
    int          en_cyc;
    logic [31:0] en_addr, en_wdata;
    logic [3:0]  en_be;
    logic        en_we;
    int          gseq[$];

    // model: at most one access in flight, described as a timeline of cycles
    int          busy_lo = 0, busy_hi = -1, iss_cyc = -1, rsp_at = -1;
    logic        m_rr = 1'b0, rst_prev = 1'b0, started = 1'b0;
    req_t        pend;
    logic        p_owner;
    logic [31:0] p_data;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    int          e_conf = 0, e_wait = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic e_en, e_we, e_rv0, e_rv1, e_busy, e_rdy0, e_rdy1, gr, idle_ok;
        // memory responder
        if (mem_en === 1'b1) begin
            if (mem_we) dmem[mem_addr] = merge(dmem.exists(mem_addr) ? dmem[mem_addr] : init_val(mem_addr), mem_wdata, mem_be);
            else        rd_at[cyc + LAT] = dmem.exists(mem_addr) ? dmem[mem_addr] : init_val(mem_addr);
        end
        mem_rdata = rd_at.exists(cyc) ? rd_at[cyc] : (32'h0BAD_0000 | 32'(cyc[15:0]));

        // expected registered outputs for this cycle
        if (rst_prev) begin
            e_en = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0;
            e_addr = 0; e_wdata = 0; e_be = 0;
        end else begin
            e_en = (cyc == iss_cyc);
            e_we = e_en && pend.we;
            if (e_en) begin
                e_addr = pend.addr; e_wdata = pend.wdata; e_be = pend.be;
                if (pend.we) begin
                    rmem[pend.addr] = merge(rmem.exists(pend.addr) ? rmem[pend.addr] : init_val(pend.addr), pend.wdata, pend.be);
                    p_data = 0;
                end else begin
                    p_data = rmem.exists(pend.addr) ? rmem[pend.addr] : init_val(pend.addr);
                end
            end
            e_rv0 = (cyc == rsp_at) && !p_owner;
            e_rv1 = (cyc == rsp_at) && p_owner;
        end
        e_busy  = (cyc >= busy_lo) && (cyc <= busy_hi);
        idle_ok = reset && (cyc > busy_hi);
        gr      = (l0_req_valid && l1_req_valid) ? m_rr : l1_req_valid;
        e_rdy0  = idle_ok && l0_req_valid && !gr;
        e_rdy1  = idle_ok && l1_req_valid && gr;

        if (started) begin
            chk("l0_req_ready", l0_req_ready, e_rdy0);
            chk("l1_req_ready", l1_req_ready, e_rdy1);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_be", mem_be, e_be);
            chk("l0_rsp_valid", l0_rsp_valid, e_rv0);
            chk("l1_rsp_valid", l1_rsp_valid, e_rv1);
            if (e_rv0) chk("l0_rsp_rdata", l0_rsp_rdata, p_data);
            if (e_rv1) chk("l1_rsp_rdata", l1_rsp_rdata, p_data);
            chk("busy", busy, e_busy);
`ifdef DMEM_ARB_STATS_EN
            chk("conflict_cnt", conflict_cnt, e_conf);
            chk("wait_cnt", wait_cnt, e_wait);
`endif
        end

        // logs from observed DUT behaviour
        acc0 = l0_req_valid && (l0_req_ready === 1'b1);
        acc1 = l1_req_valid && (l1_req_ready === 1'b1);
        if (acc0) begin hs_cyc[0] = cyc; hs_cnt[0]++; gseq.push_back(0); end
        if (acc1) begin hs_cyc[1] = cyc; hs_cnt[1]++; gseq.push_back(1); end
        if (l0_rsp_valid === 1'b1) begin rsp_cyc[0] = cyc; rsp_cnt[0]++; rsp_dat[0] = l0_rsp_rdata; end
        if (l1_rsp_valid === 1'b1) begin rsp_cyc[1] = cyc; rsp_cnt[1]++; rsp_dat[1] = l1_rsp_rdata; end
        if (mem_en === 1'b1) begin
            en_cyc = cyc; en_addr = mem_addr; en_wdata = mem_wdata; en_be = mem_be; en_we = mem_we;
        end

        // advance the model across the coming edge
        if (!reset) begin
            iss_cyc = -1; rsp_at = -1;
            if (busy_hi > cyc) busy_hi = cyc;
            m_rr = 0; rst_prev = 1; started = 1;
            e_conf = 0; e_wait = 0;
        end else begin
            rst_prev = 0;
            if ((l0_req_valid && !e_rdy0) || (l1_req_valid && !e_rdy1))
                e_wait = (e_wait < (1 << CW) - 1) ? e_wait + 1 : e_wait;
            if (e_rdy0 || e_rdy1) begin
                p_owner = e_rdy1;
                pend = e_rdy1 ? req_t'{l1_req_we, l1_req_addr, l1_req_wdata, l1_req_be}
                              : req_t'{l0_req_we, l0_req_addr, l0_req_wdata, l0_req_be};
                iss_cyc = cyc + 1;
                rsp_at  = cyc + 2 + LAT;
                busy_lo = cyc + 1;
                busy_hi = cyc + 2 + LAT;
                m_rr    = !e_rdy1;
                if (l0_req_valid && l1_req_valid)
                    e_conf = (e_conf < (1 << CW) - 1) ? e_conf + 1 : e_conf;
            end
        end
    end

    // lane drivers: present the queue head, pop it once accepted
    always @(posedge clk) begin
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        acc0 = 0; acc1 = 0;
        l0_req_valid = (q0.size() > 0);
        if (q0.size() > 0) {l0_req_we, l0_req_addr, l0_req_wdata, l0_req_be} = q0[0];
        l1_req_valid = (q1.size() > 0);
        if (q1.size() > 0) {l1_req_we, l1_req_addr, l1_req_wdata, l1_req_be} = q1[0];
    end

    task automatic push(input int lane, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        if (lane == 0) q0.push_back(req_t'{we, a, d, be});
        else           q1.push_back(req_t'{we, a, d, be});
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 reset = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((q0.size() > 0 || q1.size() > 0 || busy !== 1'b0) && n < 200);
        chk("wait_idle_in_budget", n < 200, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int c0, r0, n;
        reset = 0;
        mem_rdata = 0;
        l0_req_valid = 0; l0_req_we = 0; l0_req_addr = 0; l0_req_wdata = 0; l0_req_be = 0;
        l1_req_valid = 0; l1_req_we = 0; l1_req_addr = 0; l1_req_wdata = 0; l1_req_be = 0;
        dmem[32'h10] = 32'hDEAD_BEEF; rmem[32'h10] = 32'hDEAD_BEEF;
        dmem[32'h40] = 32'h1122_3344; rmem[32'h40] = 32'h1122_3344;

        // reset held with lane0 requesting
        push(0, 0, 32'h10, 0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_l0_valid_held", l0_req_valid, 1);
            chk("rst_l0_ready", l0_req_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_rsp_valid", {l0_rsp_valid, l1_rsp_valid}, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk); #1 reset = 1;

        // lane0 load 0x10
        wait_idle();
        chk("t2_en_lat", en_cyc - hs_cyc[0], 1);
        chk("t2_rsp_lat", rsp_cyc[0] - hs_cyc[0], 4);
        chk("t2_rdata", rsp_dat[0], 32'hDEAD_BEEF);
        chk("t2_addr", en_addr, 32'h10);

        // simultaneous requests right after reset
        do_reset();
        push(0, 0, 32'h20, 0, 4'hF);
        push(1, 0, 32'h24, 0, 4'hF);
        wait_idle();
        chk("t3_l1_hs", hs_cyc[1] - hs_cyc[0], 5);
        chk("t3_l1_rsp", rsp_cyc[1] - hs_cyc[0], 9);
        chk("t3_l1_en", en_cyc - hs_cyc[0], 6);
        chk("t3_l1_addr", en_addr, 32'h24);
        chk("t3_l0_data", rsp_dat[0], 32'h5A5A_0020);
        chk("t3_l1_data", rsp_dat[1], 32'h5A5A_0024);

        // lane1 partial store, then lane0 reads it back
        r0 = rsp_cnt[1];
        push(1, 1, 32'h40, 32'hCAFE_F00D, 4'b0011);
        wait_idle();
        chk("t4_we", en_we, 1);
        chk("t4_be", en_be, 4'b0011);
        chk("t4_wdata", en_wdata, 32'hCAFE_F00D);
        chk("t4_rsp_cnt", rsp_cnt[1] - r0, 1);
        chk("t4_rsp_zero", rsp_dat[1], 0);
        push(0, 0, 32'h40, 0, 4'hF);
        wait_idle();
        chk("t4_readback", rsp_dat[0], 32'h1122_F00D);

        // reset while the access is in WAIT
        r0 = rsp_cnt[0];
        c0 = hs_cnt[0];
        push(0, 0, 32'h50, 0, 4'hF);
        n = 0;
        while (hs_cnt[0] == c0 && n < 50) begin @(posedge clk); n++; end
        chk("t5_hs_seen", n < 50, 1);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 reset = 1;
        repeat (8) @(posedge clk);
        chk("t5_no_rsp", rsp_cnt[0] - r0, 0);
        chk("t5_busy", busy, 0);
        gseq.delete();
        push(1, 0, 32'h54, 0, 4'hF);
        push(0, 0, 32'h58, 0, 4'hF);
        wait_idle();
        chk("t5_order_len", gseq.size(), 2);
        if (gseq.size() == 2) begin
            chk("t5_first_lane0", gseq[0], 0);
            chk("t5_then_lane1", gseq[1], 1);
        end

`ifdef DMEM_ARB_STATS_EN
        // four lane0/lane1 pairs queued together; counters start from reset
        do_reset();
        gseq.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 0, 32'h100 + 32'(8 * i), 0, 4'hF);
            push(1, 0, 32'h104 + 32'(8 * i), 0, 4'hF);
        end
        wait_idle();
        chk("t6_grants", gseq.size(), 8);
        foreach (gseq[i]) chk("t6_alternate", gseq[i], i % 2);
        chk("t6_conflict_cnt", conflict_cnt, 7);
        chk("t6_wait_cnt_sat", wait_cnt, 15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
